cmp_argext_seq: RTL and testbench

Sequencer that time-shares one two-input comparator (the team's `DW01_cmp2`, instantiated internally with `WIDTH` matching) to find the maximum or minimum value, and its index, in a bank of up to `DEPTH` words held in an external synchronous-read RAM. It sits beside the spin/energy buffers in the behavioural simulator. Typical use is picking the best candidate out of a sample set without building a comparator tree. A start/done handshake drives it. Per-run configuration selects signed or unsigned compare, min or max, and first-or-last tie resolution.

---
 rtl/cmp_argext_seq.sv | 192 +++++++++++++++++++
 tb/tb_cmp_argext_seq.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_argext_seq.sv
// Arg-max/arg-min sequencer: walks a synchronous-read RAM through one shared comparator
// and reports the winning value and its index with a start/done handshake.
module cmp_argext_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 64,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [IDX_W:0]   len_i,
    input  logic             mode_min_i,
    input  logic             tc_i,
    input  logic             tie_last_i,
    input  logic             abort_i,
    output logic             rd_en_o,
    output logic [IDX_W-1:0] rd_addr_o,
    input  logic [WIDTH-1:0] rd_data_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             res_valid_o,
    output logic [WIDTH-1:0] best_val_o,
    output logic [IDX_W-1:0] best_idx_o
);
    typedef enum logic [1:0] {StIdle, StFetch, StScan, StDone} state_e;

    localparam logic [IDX_W:0] LenMax = (IDX_W + 1)'(DEPTH);

    state_e           state_q;
    logic [IDX_W:0]   len_q;
    logic             mode_min_q, tc_q, tie_last_q, abort_q, empty_q;
    logic             rd_en_q, vld_q;
    logic [IDX_W-1:0] rd_addr_q, k_q, run_idx_q;
    logic [WIDTH-1:0] run_val_q;
    logic             busy_q, done_q, res_valid_q;
    logic [WIDTH-1:0] best_val_q;
    logic [IDX_W-1:0] best_idx_q;

    logic [IDX_W:0]   len_clamp, next_addr;
    logic             leq, lt_le, ge_gt, hit, upd;
    logic [WIDTH-1:0] win_val;
    logic [IDX_W-1:0] win_idx;

    always_comb begin
        len_clamp = (len_i > LenMax) ? LenMax : len_i;
        next_addr = {1'b0, rd_addr_q} + (IDX_W + 1)'(1);
    end

    // LEQ picks strict vs. inclusive compare so ties resolve toward the requested end.
    assign leq = ~(mode_min_q ^ tie_last_q);

    DW01_cmp2 #(
        .WIDTH (WIDTH)
    ) u_cmp (
        .A     (rd_data_i),
        .B     (run_val_q),
        .LEQ   (leq),
        .TC    (tc_q),
        .LT_LE (lt_le),
        .GE_GT (ge_gt)
    );

    // vld_q/k_q describe the element currently on rd_data_i; element 0 always loads.
    always_comb begin
        hit     = mode_min_q ? lt_le : ge_gt;
        upd     = vld_q & ((k_q == '0) | hit);
        win_val = upd ? rd_data_i : run_val_q;
        win_idx = upd ? k_q : run_idx_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            len_q       <= '0;
            mode_min_q  <= 1'b0;
            tc_q        <= 1'b0;
            tie_last_q  <= 1'b0;
            abort_q     <= 1'b0;
            empty_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            vld_q       <= 1'b0;
            rd_addr_q   <= '0;
            k_q         <= '0;
            run_idx_q   <= '0;
            run_val_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            res_valid_q <= 1'b0;
            best_val_q  <= '0;
            best_idx_q  <= '0;
        end else begin
            busy_q <= (state_q == StFetch) || (state_q == StScan);
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        mode_min_q <= mode_min_i;
                        tc_q       <= tc_i;
                        tie_last_q <= tie_last_i;
                        len_q      <= len_clamp;
                        abort_q    <= 1'b0;
                        empty_q    <= (len_clamp == '0);
                        state_q    <= (len_clamp == '0) ? StDone : StFetch;
                    end
                end
                StFetch: begin
                    if (abort_i) begin
                        abort_q <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= '0;
                        vld_q     <= 1'b0;
                        state_q   <= StScan;
                    end
                end
                StScan: begin
                    if (abort_i) begin
                        abort_q <= 1'b1;
                        rd_en_q <= 1'b0;
                        vld_q   <= 1'b0;
                        state_q <= StDone;
                    end else begin
                        vld_q     <= rd_en_q;
                        k_q       <= rd_addr_q;
                        run_val_q <= win_val;
                        run_idx_q <= win_idx;
                        if (next_addr < len_q) begin
                            rd_addr_q <= next_addr[IDX_W-1:0];
                        end else begin
                            rd_en_q <= 1'b0;
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    // The last element is still on rd_data_i here, so take the live winner.
                    done_q  <= 1'b1;
                    vld_q   <= 1'b0;
                    state_q <= StIdle;
                    if (abort_q) begin
                        res_valid_q <= 1'b0;
                    end else begin
                        res_valid_q <= ~empty_q;
                        best_val_q  <= empty_q ? '0 : win_val;
                        best_idx_q  <= empty_q ? '0 : win_idx;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rd_en_o     = rd_en_q;
    assign rd_addr_o   = rd_addr_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign res_valid_o = res_valid_q;
    assign best_val_o  = best_val_q;
    assign best_idx_o  = best_idx_q;

endmodule

// Two-input magnitude comparator; TC selects signed, LEQ selects strict vs. inclusive sense.
module DW01_cmp2 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             LEQ,
    input  logic             TC,
    output logic             LT_LE,
    output logic             GE_GT
);
    logic [WIDTH-1:0] a_adj, b_adj;
    logic             lt, eq;

    // Flipping the sign bits maps two's complement order onto unsigned order.
    always_comb begin
        a_adj = A;
        b_adj = B;
        if (TC) begin
            a_adj[WIDTH-1] = ~A[WIDTH-1];
            b_adj[WIDTH-1] = ~B[WIDTH-1];
        end
        lt    = a_adj < b_adj;
        eq    = A == B;
        LT_LE = LEQ ? (lt | eq) : lt;
        GE_GT = LEQ ? ~(lt | eq) : ~lt;
    end

endmodule

// File: tb/tb_cmp_argext_seq.sv
// Directed bench for cmp_argext_seq: RAM model plus per-scenario tasks with fixed expectations.
module tb_cmp_argext_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort, mode_min, tc, tie_last;
    logic [6:0]  len;
    logic        rd_en;
    logic [5:0]  rd_addr;
    logic [15:0] rd_data;
    logic        busy, done, res_valid;
    logic [15:0] best_val;
    logic [5:0]  best_idx;

    logic [15:0] mem [64];
    logic [6:0]  exp_len = 7'd0;
    int          n_reads = 0;
    int          n_bad_addr = 0;
    logic [5:0]  last_addr = 6'd0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    cmp_argext_seq #(
        .WIDTH (16),
        .DEPTH (64)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start),
        .len_i       (len),
        .mode_min_i  (mode_min),
        .tc_i        (tc),
        .tie_last_i  (tie_last),
        .abort_i     (abort),
        .rd_en_o     (rd_en),
        .rd_addr_o   (rd_addr),
        .rd_data_i   (rd_data),
        .busy_o      (busy),
        .done_o      (done),
        .res_valid_o (res_valid),
        .best_val_o  (best_val),
        .best_idx_o  (best_idx)
    );

    always @(posedge clk) begin
        if (rd_en) begin
            rd_data   <= mem[rd_addr];
            n_reads   <= n_reads + 1;
            last_addr <= rd_addr;
            if ({1'b0, rd_addr} >= exp_len) n_bad_addr <= n_bad_addr + 1;
        end
    end

    // Cycle c is observed 1 time unit after edge c; start is sampled at edge 0.
    task automatic do_run(input logic [6:0] n, input logic mm, input logic tcv, input logic tl,
                          input int abort_at, input int restart_at,
                          output int done_at, output int busy_err, output int reads);
        int r0;
        r0 = n_reads;
        @(negedge clk);
        start = 1'b1; len = n; mode_min = mm; tc = tcv; tie_last = tl;
        exp_len = (n > 7'd64) ? 7'd64 : n;
        @(posedge clk);
        done_at  = -1;
        busy_err = 0;
        for (int c = 1; c <= 200 && done_at < 0; c++) begin
            @(negedge clk);
            start = (c == restart_at);
            abort = (c == abort_at);
            if (c == restart_at) begin
                mode_min = ~mm; tc = ~tcv; tie_last = ~tl; len = 7'd2;
            end
            @(posedge clk);
            #1;
            if (busy !== ~done) busy_err++;
            if (done === 1'b1) done_at = c;
        end
        start = 1'b0;
        abort = 1'b0;
        reads = n_reads - r0;
    endtask

    task automatic test_reset;
        total++;
        if ({busy, done, res_valid, rd_en, rd_addr, best_val, best_idx} !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0",
                     {busy, done, res_valid, rd_en, rd_addr, best_val, best_idx});
        end
    endtask

    task automatic test_max_first;
        int d, be, r;
        mem[0] = 16'd3; mem[1] = 16'd9; mem[2] = 16'd2; mem[3] = 16'd9; mem[4] = 16'd1;
        do_run(7'd5, 1'b0, 1'b0, 1'b0, 0, 0, d, be, r);
        total++; if (d !== 7) begin bad++; $display("FAIL max_first done_cycle: got %0d want 7", d); end
        total++; if (best_val !== 16'd9) begin bad++; $display("FAIL max_first val: got %0d want 9", best_val); end
        total++; if (best_idx !== 6'd1) begin bad++; $display("FAIL max_first idx: got %0d want 1", best_idx); end
        total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL max_first valid: got %b want 1", res_valid); end
        total++; if (be !== 0) begin bad++; $display("FAIL max_first busy: got %0d bad cycles want 0", be); end
        total++; if (r !== 5) begin bad++; $display("FAIL max_first reads: got %0d want 5", r); end
    endtask

    task automatic test_max_last;
        int d, be, r;
        do_run(7'd5, 1'b0, 1'b0, 1'b1, 0, 0, d, be, r);
        total++; if (best_idx !== 6'd3) begin bad++; $display("FAIL max_last idx: got %0d want 3", best_idx); end
        total++; if (best_val !== 16'd9) begin bad++; $display("FAIL max_last val: got %0d want 9", best_val); end
    endtask

    task automatic test_min_first;
        int d, be, r;
        do_run(7'd5, 1'b1, 1'b0, 1'b0, 0, 0, d, be, r);
        total++; if (best_val !== 16'd1) begin bad++; $display("FAIL min_first val: got %0d want 1", best_val); end
        total++; if (best_idx !== 6'd4) begin bad++; $display("FAIL min_first idx: got %0d want 4", best_idx); end
    endtask

    task automatic test_signed;
        int d, be, r;
        mem[0] = 16'h0005; mem[1] = 16'hFFF0; mem[2] = 16'h7FFF; mem[3] = 16'hFFF0;
        do_run(7'd4, 1'b1, 1'b1, 1'b0, 0, 0, d, be, r);
        total++; if (best_val !== 16'hFFF0) begin bad++; $display("FAIL signed_min val: got %h want fff0", best_val); end
        total++; if (best_idx !== 6'd1) begin bad++; $display("FAIL signed_min idx: got %0d want 1", best_idx); end
        total++; if (d !== 6) begin bad++; $display("FAIL signed_min done_cycle: got %0d want 6", d); end
        do_run(7'd4, 1'b1, 1'b0, 1'b0, 0, 0, d, be, r);
        total++; if (best_val !== 16'h0005) begin bad++; $display("FAIL unsigned_min val: got %h want 0005", best_val); end
        total++; if (best_idx !== 6'd0) begin bad++; $display("FAIL unsigned_min idx: got %0d want 0", best_idx); end
    endtask

    task automatic test_start_ignored;
        int d, be, r, r0, b;
        mem[0] = 16'd3; mem[1] = 16'd9; mem[2] = 16'd2; mem[3] = 16'd9; mem[4] = 16'd1;
        do_run(7'd5, 1'b0, 1'b0, 1'b0, 0, 3, d, be, r);
        total++; if (d !== 7) begin bad++; $display("FAIL restart done_cycle: got %0d want 7", d); end
        total++; if (best_val !== 16'd9 || best_idx !== 6'd1) begin
            bad++; $display("FAIL restart result: got %0d@%0d want 9@1", best_val, best_idx);
        end
        r0 = n_reads;
        b  = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (busy !== 1'b0 || done !== 1'b0) b++;
        end
        total++; if (b !== 0 || n_reads !== r0) begin
            bad++; $display("FAIL restart queued: got %0d busy cycles %0d reads want 0 0", b, n_reads - r0);
        end
    endtask

    task automatic test_abort;
        int d, be, r;
        do_run(7'd8, 1'b1, 1'b0, 1'b0, 3, 0, d, be, r);
        total++; if (d !== 4) begin bad++; $display("FAIL abort done_cycle: got %0d want 4", d); end
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL abort valid: got %b want 0", res_valid); end
        total++; if (best_val !== 16'd9 || best_idx !== 6'd1) begin
            bad++; $display("FAIL abort held: got %0d@%0d want 9@1", best_val, best_idx);
        end
        total++; if (r !== 2) begin bad++; $display("FAIL abort reads: got %0d want 2", r); end
        total++; if (be !== 0) begin bad++; $display("FAIL abort busy: got %0d bad cycles want 0", be); end
    endtask

    task automatic test_len0;
        int d, be, r;
        do_run(7'd0, 1'b0, 1'b0, 1'b0, 0, 0, d, be, r);
        total++; if (d !== 1) begin bad++; $display("FAIL len0 done_cycle: got %0d want 1", d); end
        total++; if ({res_valid, best_val, best_idx} !== 23'h0) begin
            bad++; $display("FAIL len0 result: got %b/%h/%0d want 0/0/0", res_valid, best_val, best_idx);
        end
        total++; if (r !== 0) begin bad++; $display("FAIL len0 reads: got %0d want 0", r); end
    endtask

    task automatic test_len_clamp;
        int d, be, r, ba;
        for (int i = 0; i < 64; i++) mem[i] = 16'(i);
        ba = n_bad_addr;
        do_run(7'd69, 1'b0, 1'b0, 1'b0, 0, 0, d, be, r);
        total++; if (r !== 64) begin bad++; $display("FAIL clamp reads: got %0d want 64", r); end
        total++; if (last_addr !== 6'd63) begin bad++; $display("FAIL clamp last_addr: got %0d want 63", last_addr); end
        total++; if (n_bad_addr !== ba) begin bad++; $display("FAIL clamp addr_range: got %0d want 0", n_bad_addr - ba); end
        total++; if (d !== 66) begin bad++; $display("FAIL clamp done_cycle: got %0d want 66", d); end
        total++; if (best_val !== 16'd63 || best_idx !== 6'd63) begin
            bad++; $display("FAIL clamp result: got %0d@%0d want 63@63", best_val, best_idx);
        end
    endtask

    task automatic test_back_to_back;
        int d, be, r;
        mem[0] = 16'd3; mem[1] = 16'd9; mem[2] = 16'd2; mem[3] = 16'd9; mem[4] = 16'd1;
        do_run(7'd5, 1'b0, 1'b0, 1'b1, 0, 0, d, be, r);
        total++; if (best_idx !== 6'd3) begin bad++; $display("FAIL b2b_first idx: got %0d want 3", best_idx); end
        do_run(7'd3, 1'b1, 1'b0, 1'b0, 0, 0, d, be, r);
        total++; if (d !== 5) begin bad++; $display("FAIL b2b_second done_cycle: got %0d want 5", d); end
        total++; if (best_val !== 16'd2 || best_idx !== 6'd2) begin
            bad++; $display("FAIL b2b_second result: got %0d@%0d want 2@2", best_val, best_idx);
        end
    endtask

    task automatic test_reset_mid;
        int d, be, r, seen;
        mem[0] = 16'd5; mem[1] = 16'd7; mem[2] = 16'd6;
        @(negedge clk);
        start = 1'b1; len = 7'd8; mode_min = 1'b0; tc = 1'b0; tie_last = 1'b0; exp_len = 7'd8;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if ({busy, done, res_valid, rd_en, rd_addr, best_val, best_idx} !== 32'h0) begin
            bad++; $display("FAIL reset_mid outputs: got %h want 0",
                            {busy, done, res_valid, rd_en, rd_addr, best_val, best_idx});
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL reset_mid no_done: got %0d active cycles want 0", seen); end
        do_run(7'd3, 1'b0, 1'b0, 1'b0, 0, 0, d, be, r);
        total++; if (d !== 5) begin bad++; $display("FAIL reset_mid rerun done_cycle: got %0d want 5", d); end
        total++; if (best_val !== 16'd7 || best_idx !== 6'd1 || res_valid !== 1'b1) begin
            bad++; $display("FAIL reset_mid rerun result: got %0d@%0d v%b want 7@1 v1", best_val, best_idx, res_valid);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'h0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; len = 7'd0;
        mode_min = 1'b0; tc = 1'b0; tie_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        @(negedge clk);
        rst_n = 1'b1;
        test_max_first;
        test_max_last;
        test_min_first;
        test_signed;
        test_start_ignored;
        test_abort;
        test_len0;
        test_len_clamp;
        test_back_to_back;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
